// File: rtl/regstat_file_mp_if.sv
// Issue/CDB-side bundle for the register file and tag table.
// master = issue unit plus CDB drivers; slave = the register file itself.
interface regstat_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int TAG_W  = 5,
  parameter int NRD    = 2,
  parameter int NBC    = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]     RdAddr;
  logic [NRD*DATA_W-1:0] RdData;
  logic [NRD*TAG_W-1:0]  RdLabel;
  logic                  RegWr;
  logic [AW-1:0]         WrAddr;
  logic [TAG_W-1:0]      WrLabel;
  logic [NBC-1:0]        BCEN;
  logic [NBC*TAG_W-1:0]  BClabel;
  logic [NBC*DATA_W-1:0] BCdata;
  logic                  Flush;
  logic [AW:0]           PendCnt;

  modport master (
    output RdAddr, RegWr, WrAddr, WrLabel, BCEN, BClabel, BCdata, Flush,
    input  RdData, RdLabel, PendCnt
  );

  modport slave (
    input  RdAddr, RegWr, WrAddr, WrLabel, BCEN, BClabel, BCdata, Flush,
    output RdData, RdLabel, PendCnt
  );
endinterface

// File: rtl/regstat_file_mp.sv
// Register file with producer-tag table for the Tomasulo core: multi-port reads with
// same-cycle CDB bypass, multi-channel CDB capture, rename, flush and pending count.
module regstat_file_mp #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int TAG_W  = 5,
  parameter int NRD    = 2,
  parameter int NBC    = 2
) (
  input  logic              clk,
  input  logic              nRST,
  regstat_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [DATA_W-1:0] r_data [NREG];
  logic [TAG_W-1:0]  r_tag  [NREG];
  logic [AW:0]       r_pend;

  logic [DATA_W-1:0] w_data_nxt [NREG];
  logic [TAG_W-1:0]  w_tag_nxt  [NREG];
  logic [AW:0]       w_pend_nxt;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_bc;
  logic [DATA_W-1:0] w_up_bc;

  // Scans channels high to low so the lowest matching channel is the one left in d.
  function automatic logic bc_match(
    input  logic [TAG_W-1:0]      tag,
    input  logic [NBC-1:0]        en,
    input  logic [NBC*TAG_W-1:0]  lbl,
    input  logic [NBC*DATA_W-1:0] dat,
    output logic [DATA_W-1:0]     d
  );
    bc_match = 1'b0;
    d        = '0;
    for (int c = NBC-1; c >= 0; c--) begin
      if (en[c] && (tag != '0) && (lbl[c*TAG_W +: TAG_W] == tag)) begin
        bc_match = 1'b1;
        d        = dat[c*DATA_W +: DATA_W];
      end
    end
  endfunction

  // Read ports: pre-rename view, but a broadcast completing this cycle is forwarded.
  always_comb begin
    bus.RdData  = '0;
    bus.RdLabel = '0;
    w_rd_addr   = '0;
    w_rd_bc     = '0;
    for (int k = 0; k < NRD; k++) begin
      w_rd_addr = bus.RdAddr[k*AW +: AW];
      if (w_rd_addr != '0) begin
        if (bc_match(r_tag[w_rd_addr], bus.BCEN, bus.BClabel, bus.BCdata, w_rd_bc)) begin
          bus.RdData[k*DATA_W +: DATA_W] = w_rd_bc;
        end else begin
          bus.RdData[k*DATA_W +: DATA_W] = r_data[w_rd_addr];
          bus.RdLabel[k*TAG_W +: TAG_W]  = r_tag[w_rd_addr];
        end
      end
    end
  end

  // Per-register next state: flush, then rename, then CDB capture.
  always_comb begin
    w_pend_nxt = '0;
    w_up_bc    = '0;
    for (int i = 0; i < NREG; i++) begin
      w_data_nxt[i] = r_data[i];
      w_tag_nxt[i]  = r_tag[i];
      if (i == 0) begin
        w_data_nxt[i] = '0;
        w_tag_nxt[i]  = '0;
      end else if (bus.Flush) begin
        w_tag_nxt[i] = '0;
      end else if (bus.RegWr && (bus.WrAddr == AW'(i)) && (bus.WrLabel != '0)) begin
        w_tag_nxt[i] = bus.WrLabel;
      end else if (bc_match(r_tag[i], bus.BCEN, bus.BClabel, bus.BCdata, w_up_bc)) begin
        w_data_nxt[i] = w_up_bc;
        w_tag_nxt[i]  = '0;
      end
      if (w_tag_nxt[i] != '0) begin
        w_pend_nxt = w_pend_nxt + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= w_data_nxt[i];
        r_tag[i]  <= w_tag_nxt[i];
      end
      r_pend <= w_pend_nxt;
    end
  end

  assign bus.PendCnt = r_pend;
endmodule

// File: tb/tb_regstat_file_mp.sv
// Bench for regstat_file_mp: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural register/tag model.
module tb_regstat_file_mp;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int TAG_W  = 5;
  localparam int NRD    = 2;
  localparam int NBC    = 2;
  localparam int AW     = 5;

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  regstat_file_mp_if #(.DATA_W(DATA_W), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD), .NBC(NBC)) bif();

  regstat_file_mp #(.DATA_W(DATA_W), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD), .NBC(NBC)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  logic [DATA_W-1:0] m_data [NREG];
  logic [TAG_W-1:0]  m_tag  [NREG];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First enabled channel carrying tag t (tag 0 never matches).
  function automatic logic bc_find(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    d = '0;
    if (t == 0) return 1'b0;
    for (int c = 0; c < NBC; c++) begin
      if (bif.BCEN[c] && bif.BClabel[c*TAG_W +: TAG_W] == t) begin
        d = bif.BCdata[c*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void exp_read(input int a, output logic [DATA_W-1:0] d, output logic [TAG_W-1:0] t);
    logic [DATA_W-1:0] bd;
    if (a == 0) begin
      d = '0; t = '0;
    end else if (bc_find(m_tag[a], bd)) begin
      d = bd; t = '0;
    end else begin
      d = m_data[a]; t = m_tag[a];
    end
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 1; i < NREG; i++) if (m_tag[i] != 0) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_data[i] = '0;
      m_tag[i]  = '0;
    end
  endtask

  always @(posedge clk or negedge nRST) begin : model
    logic [DATA_W-1:0] d;
    if (!nRST) begin
      model_clear();
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (bif.Flush) m_tag[i] = '0;
        else if (bif.RegWr && bif.WrAddr == i && bif.WrLabel != 0) m_tag[i] = bif.WrLabel;
        else if (bc_find(m_tag[i], d)) begin
          m_data[i] = d;
          m_tag[i]  = '0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [DATA_W-1:0] ed;
    logic [TAG_W-1:0]  et;
    if (cmp_on) begin
      for (int k = 0; k < NRD; k++) begin
        exp_read(int'(bif.RdAddr[k*AW +: AW]), ed, et);
        chk($sformatf("rd%0d_data", k), bif.RdData[k*DATA_W +: DATA_W], ed);
        chk($sformatf("rd%0d_tag", k), bif.RdLabel[k*TAG_W +: TAG_W], et);
      end
      chk("pendcnt", bif.PendCnt, pending());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.RegWr = 1'b0; bif.WrAddr = '0; bif.WrLabel = '0;
    bif.BCEN = '0; bif.BClabel = '0; bif.BCdata = '0; bif.Flush = 1'b0;
  endtask

  task automatic rename(input int a, input int t);
    bif.RegWr = 1'b1; bif.WrAddr = AW'(a); bif.WrLabel = TAG_W'(t);
  endtask

  task automatic bc(input int ch, input int t, input logic [DATA_W-1:0] d);
    bif.BCEN[ch] = 1'b1;
    bif.BClabel[ch*TAG_W +: TAG_W] = TAG_W'(t);
    bif.BCdata[ch*DATA_W +: DATA_W] = d;
  endtask

  // Reads through port 0; call only when no broadcast is active.
  task automatic expect_reg(input string nm, input int a, input logic [DATA_W-1:0] d, input int t);
    bif.RdAddr[0 +: AW] = AW'(a);
    #1;
    chk({nm, "_data"}, bif.RdData[0 +: DATA_W], d);
    chk({nm, "_tag"}, bif.RdLabel[0 +: TAG_W], t);
  endtask

  initial begin
    model_clear();
    idle();
    bif.RdAddr = '0;
    nRST = 1'b0;
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < NREG; a += 2) begin
      bif.RdAddr = {AW'(a + 1), AW'(a)};
      #1;
      chk("rst_rd0", {bif.RdData[0 +: DATA_W], 3'b0, bif.RdLabel[0 +: TAG_W]}, 64'd0);
      chk("rst_rd1", {bif.RdData[DATA_W +: DATA_W], 3'b0, bif.RdLabel[TAG_W +: TAG_W]}, 64'd0);
    end
    chk("rst_pend", bif.PendCnt, 0);
    step();
    nRST = 1'b1;

    // CDB bypass on channel 1 then capture
    step(); rename(3, 7);
    step(); idle(); bc(1, 7, 32'hDEADBEEF); bif.RdAddr[0 +: AW] = 5'd3; #1;
    chk("bypass_r3_data", bif.RdData[0 +: DATA_W], 32'hDEADBEEF);
    chk("bypass_r3_tag", bif.RdLabel[0 +: TAG_W], 0);
    chk("pend_before_bc", bif.PendCnt, 1);
    step(); idle();
    expect_reg("r3_after_bc", 3, 32'hDEADBEEF, 0);
    chk("pend_after_bc", bif.PendCnt, 0);

    // Rename beats a broadcast on the old tag
    rename(5, 4);
    step(); rename(5, 9); bc(0, 4, 32'h55); bif.RdAddr[TAG_W +: AW] = 5'd5; #1;
    chk("r5_bypass_data", bif.RdData[DATA_W +: DATA_W], 32'h55);
    chk("r5_bypass_tag", bif.RdLabel[TAG_W +: TAG_W], 0);
    step(); idle();
    expect_reg("r5_renamed", 5, 32'h0, 9);
    bc(0, 9, 32'h99);
    step(); idle();
    expect_reg("r5_cleared", 5, 32'h99, 0);

    // One broadcast clears two registers
    rename(1, 6);
    step(); rename(2, 6);
    step(); idle(); #1;
    chk("pend_two", bif.PendCnt, 2);
    bc(0, 6, 32'h11);
    step(); idle();
    expect_reg("r1_multi", 1, 32'h11, 0);
    expect_reg("r2_multi", 2, 32'h11, 0);
    chk("pend_multi", bif.PendCnt, 0);

    // Both channels match: lowest channel wins
    rename(1, 6);
    step(); idle(); bc(0, 6, 32'hA); bc(1, 6, 32'hB);
    step(); idle();
    expect_reg("r1_lowch", 1, 32'hA, 0);

    // Flush overrides a same-cycle rename
    rename(2, 1);
    step(); rename(8, 2);
    step(); rename(31, 3);
    step(); idle(); #1;
    chk("pend_three", bif.PendCnt, 3);
    bif.Flush = 1'b1; rename(4, 3);
    step(); idle(); #1;
    chk("pend_flush", bif.PendCnt, 0);
    expect_reg("r2_flush", 2, 32'h11, 0);
    expect_reg("r4_flush", 4, 32'h0, 0);
    step();
    expect_reg("r31_flush", 31, 32'h0, 0);
    rename(0, 5);
    step(); idle();
    expect_reg("r0_ignored", 0, 32'h0, 0);
    chk("pend_r0", bif.PendCnt, 0);

    // Randomized traffic with a mid-run asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!nRST) nRST = 1'b1;
      bif.RegWr   = ($urandom_range(0, 2) == 0);
      bif.WrAddr  = AW'($urandom_range(0, NREG-1));
      bif.WrLabel = TAG_W'($urandom_range(0, 7));
      bif.BCEN    = NBC'($urandom_range(0, 3));
      for (int c = 0; c < NBC; c++) begin
        bif.BClabel[c*TAG_W +: TAG_W]   = TAG_W'($urandom_range(0, 7));
        bif.BCdata[c*DATA_W +: DATA_W] = $urandom;
      end
      bif.Flush  = ($urandom_range(0, 49) == 0);
      bif.RdAddr = {AW'($urandom_range(0, NREG-1)), AW'($urandom_range(0, NREG-1))};
      if (n == 1500) begin
        #2 nRST = 1'b0;
        #1;
        chk("midrst_pend", bif.PendCnt, 0);
        chk("midrst_data", bif.RdData, 0);
        chk("midrst_tag", bif.RdLabel, 0);
      end
    end

    step(); idle();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
